// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue stage.
//   ALU_CTR_*  4-bit operation codes understood by the ALU
//   OP_*       MIPS-I primary opcodes handled by the decoder
//   FUNCT_*    MIPS-I R-type function codes handled by the decoder
//   issue_state_e  occupancy of the 2-entry head/skid buffer
package alu_pkg;

  localparam logic [3:0] ALU_CTR_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTR_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTR_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTR_SLL  = 4'b0011;
  localparam logic [3:0] ALU_CTR_SRL  = 4'b0100;
  localparam logic [3:0] ALU_CTR_PASS = 4'b0101;
  localparam logic [3:0] ALU_CTR_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTR_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTR_SLTU = 4'b1000;
  localparam logic [3:0] ALU_CTR_XOR  = 4'b1011;
  localparam logic [3:0] ALU_CTR_NOR  = 4'b1100;
  localparam logic [3:0] ALU_CTR_SRA  = 4'b1110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ISSUE_EMPTY = 2'd0,
    ISSUE_ONE   = 2'd1,
    ISSUE_TWO   = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: bundles the upstream valid/ready entry bus, flush and
// the downstream ALU operand bus of the issue stage.
//   master : register-read / ALU environment (drives in_*, flush, out_ready)
//   slave  : the issue stage itself (drives in_ready and out_*)
interface alu_issue_stage_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_alu_ctr;
  logic [DATA_W-1:0] out_input1;
  logic [DATA_W-1:0] out_input2;
  logic [4:0]        out_wreg;
  logic              out_reg_write;
  logic              out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_rs_val, in_rt_val, out_ready,
    input  in_ready, out_valid, out_alu_ctr, out_input1, out_input2,
           out_wreg, out_reg_write, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_rs_val, in_rt_val, out_ready,
    output in_ready, out_valid, out_alu_ctr, out_input1, out_input2,
           out_wreg, out_reg_write, out_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational MIPS-I decode of instruction + operands
// into ALU control code, operand pair and destination.
// Ports: inst, rs_val, rt_val in; alu_ctr, input1, input2, wreg,
//        reg_write, illegal out.
// Build option: ALU_ISSUE_LUI_EN adds lui (op 0F) as SLL of the zero-extended
// immediate by 16; without it op 0F decodes as illegal.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [3:0]        alu_ctr,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [4:0]        wreg,
  output logic              reg_write,
  output logic              illegal
);
  logic [5:0]        op, funct;
  logic [4:0]        rt, rd, shamt;
  logic [DATA_W-1:0] imm_sext, imm_zext, shamt_ext, rs_shift_ext;
  logic              no_write;

  assign op           = inst[31:26];
  assign rt           = inst[20:16];
  assign rd           = inst[15:11];
  assign shamt        = inst[10:6];
  assign funct        = inst[5:0];
  assign imm_sext     = {{(DATA_W-16){inst[15]}}, inst[15:0]};
  assign imm_zext     = {{(DATA_W-16){1'b0}}, inst[15:0]};
  assign shamt_ext    = {{(DATA_W-5){1'b0}}, shamt};
  assign rs_shift_ext = {{(DATA_W-5){1'b0}}, rs_val[4:0]};

  always_comb begin
    alu_ctr  = ALU_CTR_PASS;
    input1   = rs_val;
    input2   = '0;
    wreg     = '0;
    illegal  = 1'b0;
    no_write = 1'b0;
    if (op == OP_RTYPE) begin
      wreg   = rd;
      input2 = rt_val;
      case (funct)
        FUNCT_ADD, FUNCT_ADDU: alu_ctr = ALU_CTR_ADD;
        FUNCT_SUB, FUNCT_SUBU: alu_ctr = ALU_CTR_SUB;
        FUNCT_AND:  alu_ctr = ALU_CTR_AND;
        FUNCT_OR:   alu_ctr = ALU_CTR_OR;
        FUNCT_XOR:  alu_ctr = ALU_CTR_XOR;
        FUNCT_NOR:  alu_ctr = ALU_CTR_NOR;
        FUNCT_SLT:  alu_ctr = ALU_CTR_SLT;
        FUNCT_SLTU: alu_ctr = ALU_CTR_SLTU;
        FUNCT_SLL:  begin alu_ctr = ALU_CTR_SLL; input1 = shamt_ext;    end
        FUNCT_SRL:  begin alu_ctr = ALU_CTR_SRL; input1 = shamt_ext;    end
        FUNCT_SRA:  begin alu_ctr = ALU_CTR_SRA; input1 = shamt_ext;    end
        FUNCT_SLLV: begin alu_ctr = ALU_CTR_SLL; input1 = rs_shift_ext; end
        FUNCT_SRLV: begin alu_ctr = ALU_CTR_SRL; input1 = rs_shift_ext; end
        FUNCT_SRAV: begin alu_ctr = ALU_CTR_SRA; input1 = rs_shift_ext; end
        default:    illegal = 1'b1;
      endcase
    end else begin
      wreg = rt;
      case (op)
        OP_ADDI, OP_ADDIU, OP_LW: begin alu_ctr = ALU_CTR_ADD;  input2 = imm_sext; end
        OP_SW:    begin alu_ctr = ALU_CTR_ADD;  input2 = imm_sext; no_write = 1'b1; end
        OP_SLTI:  begin alu_ctr = ALU_CTR_SLT;  input2 = imm_sext; end
        OP_SLTIU: begin alu_ctr = ALU_CTR_SLTU; input2 = imm_sext; end
        OP_ANDI:  begin alu_ctr = ALU_CTR_AND;  input2 = imm_zext; end
        OP_ORI:   begin alu_ctr = ALU_CTR_OR;   input2 = imm_zext; end
        OP_XORI:  begin alu_ctr = ALU_CTR_XOR;  input2 = imm_zext; end
        OP_BEQ, OP_BNE: begin alu_ctr = ALU_CTR_SUB; input2 = rt_val; no_write = 1'b1; end
`ifdef ALU_ISSUE_LUI_EN
        OP_LUI: begin
          alu_ctr = ALU_CTR_SLL;
          input1  = {{(DATA_W-5){1'b0}}, 5'd16};
          input2  = imm_zext;
        end
`endif
        default: illegal = 1'b1;
      endcase
    end
    // Illegal encodings pass rs through so the ALU sees a harmless op.
    if (illegal) begin
      alu_ctr = ALU_CTR_PASS;
      input1  = rs_val;
      input2  = '0;
      wreg    = '0;
    end
    reg_write = !illegal && !no_write && (wreg != 5'd0);
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes entries on acceptance and holds them in a
// 2-entry head/skid buffer feeding the ALU with registered operands.
// Ports: clk, rst_n (synchronous, active low), bus (alu_issue_stage_if.slave:
//        flush, in_* valid/ready entry, out_* valid/ready ALU operands).
//
// state       | meaning
// ISSUE_EMPTY | no entry buffered, out_valid low
// ISSUE_ONE   | head holds the oldest entry, skid free
// ISSUE_TWO   | head and skid both full, in_ready low
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);
  typedef struct packed {
    logic [3:0]        alu_ctr;
    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic [4:0]        wreg;
    logic              reg_write;
    logic              illegal;
  } entry_t;

  issue_state_e state, state_next;
  entry_t       head, skid, dec;
  logic         accept, pop, head_from_dec, head_from_skid, skid_load;

  alu_issue_decode #(.DATA_W(DATA_W)) u_decode (
    .inst      (bus.in_inst),
    .rs_val    (bus.in_rs_val),
    .rt_val    (bus.in_rt_val),
    .alu_ctr   (dec.alu_ctr),
    .input1    (dec.input1),
    .input2    (dec.input2),
    .wreg      (dec.wreg),
    .reg_write (dec.reg_write),
    .illegal   (dec.illegal)
  );

  assign bus.in_ready      = (state != ISSUE_TWO);
  assign bus.out_valid     = (state != ISSUE_EMPTY);
  assign accept            = bus.in_valid && bus.in_ready;
  assign pop               = bus.out_valid && bus.out_ready;
  assign bus.out_alu_ctr   = head.alu_ctr;
  assign bus.out_input1    = head.input1;
  assign bus.out_input2    = head.input2;
  assign bus.out_wreg      = head.wreg;
  assign bus.out_reg_write = head.reg_write;
  assign bus.out_illegal   = head.illegal;

  always_comb begin
    state_next     = state;
    head_from_dec  = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (bus.flush) begin
      state_next = ISSUE_EMPTY;
    end else begin
      case (state)
        ISSUE_EMPTY: if (accept) begin
          state_next    = ISSUE_ONE;
          head_from_dec = 1'b1;
        end
        ISSUE_ONE: begin
          if (accept && pop) begin
            head_from_dec = 1'b1;
          end else if (accept) begin
            state_next = ISSUE_TWO;
            skid_load  = 1'b1;
          end else if (pop) begin
            state_next = ISSUE_EMPTY;
          end
        end
        ISSUE_TWO: if (pop) begin
          state_next     = ISSUE_ONE;
          head_from_skid = 1'b1;
        end
        default: state_next = ISSUE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ISSUE_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_next;
      if (head_from_dec)       head <= dec;
      else if (head_from_skid) head <= skid;
      if (skid_load)           skid <= dec;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized stimulus for alu_issue_stage,
// checked against a queue-based reference model with a table-style decoder.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_W(32)) bus ();
  alu_issue_stage #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]  ctr;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  wreg;
    logic        we;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_enc(int rs, int rt, int rd, int sh, int fn);
    r_enc = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_enc(int op, int rs, int rt, int imm);
    i_enc = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic ent_t ref_dec(logic [31:0] inst, logic [31:0] a, logic [31:0] b);
    ent_t        e;
    logic [5:0]  op = inst[31:26];
    logic [5:0]  fn = inst[5:0];
    logic [31:0] se = {{16{inst[15]}}, inst[15:0]};
    logic [31:0] ze = {16'h0000, inst[15:0]};
    bit          known = 1;
    bit          wr = 1;
    e.in1 = a; e.in2 = b; e.wreg = inst[15:11]; e.ctr = 4'd5; e.we = 0; e.ill = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: e.ctr = 4'd2;
        6'h22, 6'h23: e.ctr = 4'd6;
        6'h24: e.ctr = 4'd0;
        6'h25: e.ctr = 4'd1;
        6'h26: e.ctr = 4'd11;
        6'h27: e.ctr = 4'd12;
        6'h2A: e.ctr = 4'd7;
        6'h2B: e.ctr = 4'd8;
        6'h00: begin e.ctr = 4'd3;  e.in1 = 32'(inst[10:6]); end
        6'h02: begin e.ctr = 4'd4;  e.in1 = 32'(inst[10:6]); end
        6'h03: begin e.ctr = 4'd14; e.in1 = 32'(inst[10:6]); end
        6'h04: begin e.ctr = 4'd3;  e.in1 = a % 32; end
        6'h06: begin e.ctr = 4'd4;  e.in1 = a % 32; end
        6'h07: begin e.ctr = 4'd14; e.in1 = a % 32; end
        default: known = 0;
      endcase
    end else begin
      e.wreg = inst[20:16];
      case (op)
        6'h08, 6'h09, 6'h23: begin e.ctr = 4'd2; e.in2 = se; end
        6'h2B: begin e.ctr = 4'd2; e.in2 = se; wr = 0; end
        6'h0A: begin e.ctr = 4'd7; e.in2 = se; end
        6'h0B: begin e.ctr = 4'd8; e.in2 = se; end
        6'h0C: begin e.ctr = 4'd0; e.in2 = ze; end
        6'h0D: begin e.ctr = 4'd1; e.in2 = ze; end
        6'h0E: begin e.ctr = 4'd11; e.in2 = ze; end
        6'h04, 6'h05: begin e.ctr = 4'd6; wr = 0; end
`ifdef ALU_ISSUE_LUI_EN
        6'h0F: begin e.ctr = 4'd3; e.in1 = 32'd16; e.in2 = ze; end
`endif
        default: known = 0;
      endcase
    end
    if (!known) begin
      e.ctr = 4'd5; e.in1 = a; e.in2 = 32'd0; e.wreg = 5'd0; e.we = 0; e.ill = 1;
    end else begin
      e.we = wr && (e.wreg != 0);
    end
    return e;
  endfunction

  // Called at a negedge: check outputs against the model, drive one cycle
  // of inputs, advance the model at the posedge, return at the next negedge.
  task automatic step(logic r, logic f, logic v, logic [31:0] inst,
                      logic [31:0] rsv, logic [31:0] rtv, logic rdy);
    ent_t e;
    bit   acc, pp;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("head_ctr", 32'(bus.out_alu_ctr), 32'(q[0].ctr));
      chk("head_in1", bus.out_input1, q[0].in1);
      chk("head_in2", bus.out_input2, q[0].in2);
      chk("head_wreg", 32'(bus.out_wreg), 32'(q[0].wreg));
      chk("head_we", 32'(bus.out_reg_write), 32'(q[0].we));
      chk("head_ill", 32'(bus.out_illegal), 32'(q[0].ill));
    end
    rst_n = r; bus.flush = f; bus.in_valid = v; bus.in_inst = inst;
    bus.in_rs_val = rsv; bus.in_rt_val = rtv; bus.out_ready = rdy;
    e   = ref_dec(inst, rsv, rtv);
    acc = v && (q.size() < 2);
    pp  = rdy && (q.size() > 0);
    @(posedge clk);
    if (!r || f) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(logic rdy);
    step(1, 0, 0, 32'd0, 32'd0, 32'd0, rdy);
  endtask

  int unsigned op_tab[14] = '{'h00, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B,
                              'h0C, 'h0D, 'h0E, 'h0F, 'h23, 'h2B, 'h00};
  int unsigned fn_tab[16] = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h20, 'h21,
                              'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};

  initial begin
    logic [31:0] inst;
    rst_n = 0; bus.flush = 0; bus.in_valid = 0; bus.in_inst = 0;
    bus.in_rs_val = 0; bus.in_rt_val = 0; bus.out_ready = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_ctr", 32'(bus.out_alu_ctr), 0);
    chk("rst_in1", bus.out_input1, 0);
    chk("rst_in2", bus.out_input2, 0);
    chk("rst_wreg_we_ill", {bus.out_wreg, bus.out_reg_write, bus.out_illegal}, 0);

    step(1, 0, 1, r_enc(1, 2, 3, 0, 'h20), 32'd5, 32'd7, 1);
    chk("add_ctr", 32'(bus.out_alu_ctr), 32'h2);
    chk("add_in1", bus.out_input1, 5);
    chk("add_in2", bus.out_input2, 7);
    chk("add_wreg", 32'(bus.out_wreg), 3);
    chk("add_we", 32'(bus.out_reg_write), 1);

    step(1, 0, 1, r_enc(0, 2, 4, 3, 'h03), 32'h1234, 32'h8000_0000, 1);
    chk("sra_ctr", 32'(bus.out_alu_ctr), 32'hE);
    chk("sra_in1", bus.out_input1, 3);
    chk("sra_in2", bus.out_input2, 32'h8000_0000);
    step(1, 0, 1, r_enc(2, 3, 5, 0, 'h07), 32'h25, 32'hF0, 1);
    chk("srav_in1", bus.out_input1, 5);
    step(1, 0, 1, i_enc('h08, 1, 6, 'hFFFF), 32'd9, 32'd0, 1);
    chk("addi_in2", bus.out_input2, 32'hFFFF_FFFF);
    step(1, 0, 1, i_enc('h0D, 1, 6, 'hFFFF), 32'd9, 32'd0, 1);
    chk("ori_in2", bus.out_input2, 32'h0000_FFFF);
    step(1, 0, 1, i_enc('h2B, 1, 6, 'h10), 32'd9, 32'd0, 1);
    chk("sw_we", 32'(bus.out_reg_write), 0);
    idle(1);

    // Backpressure: three offers, only two fit.
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, i_enc('h08, 1, 10 + i, i), 32'd1, 32'd0, 0);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_head_wreg", 32'(bus.out_wreg), 10);
    idle(1);
    chk("bp_second_wreg", 32'(bus.out_wreg), 11);
    idle(1);
    chk("bp_drained", 32'(bus.out_valid), 0);

    // Flush while full with a same-cycle offer.
    step(1, 0, 1, i_enc('h0C, 2, 7, 'h55), 32'd3, 32'd0, 0);
    step(1, 0, 1, i_enc('h0C, 2, 8, 'h66), 32'd3, 32'd0, 0);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    step(1, 1, 1, i_enc('h0C, 2, 9, 'h77), 32'd3, 32'd0, 1);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_in_ready", 32'(bus.in_ready), 1);
    idle(1);
    chk("flush_nothing", 32'(bus.out_valid), 0);

    step(1, 0, 1, i_enc('h0F, 0, 5, 'h1234), 32'd0, 32'd0, 1);
`ifdef ALU_ISSUE_LUI_EN
    chk("lui_ctr", 32'(bus.out_alu_ctr), 32'h3);
    chk("lui_in1", bus.out_input1, 16);
    chk("lui_we", 32'(bus.out_reg_write), 1);
`else
    chk("lui_ill", 32'(bus.out_illegal), 1);
    chk("lui_we", 32'(bus.out_reg_write), 0);
`endif
    step(1, 0, 1, i_enc('h09, 1, 4, 'h3), 32'd2, 32'd0, 0);
    step(0, 1, 1, i_enc('h09, 1, 4, 'h3), 32'd2, 32'd0, 0);
    chk("rst_clears_valid", 32'(bus.out_valid), 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        inst = $urandom;
        inst[31:26] = 6'(op_tab[$urandom_range(0, 13)]);
        if (inst[31:26] == 6'h00 && $urandom_range(0, 9) < 9)
          inst[5:0] = 6'(fn_tab[$urandom_range(0, 15)]);
      end else begin
        inst = $urandom;
      end
      step($urandom_range(0, 199) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 7, inst, $urandom, $urandom,
           $urandom_range(0, 9) < 6);
    end
    idle(1); idle(1); idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
